job_responder: RTL and testbench

Responder end of the req/ack job handshake used across the status-signal blocks.
- Accepts a request from an initiator and runs a job of fixed length.
- Reports the outcome on rdy/start/endd/stop/er/status_valid/interrupt.
- Returns ack exactly LATENCY cycles after an accepted req.
- Sits between the job initiator and the status consumers; its outputs satisfy the team's standard status-signal invariants by construction.

---
 rtl/job_resp_pkg.sv | 23 ++
 rtl/job_responder.sv | 125 ++++++++++++
 tb/tb_job_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/job_resp_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// job_resp_pkg : state encoding and parameter limits for job_responder
// Rev 1.0
// ----------------------------------------------------------------------------
package job_resp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    STOP  = 3'd4,
    ERR   = 3'd5,
    POST  = 3'd6
  } job_state_e;

  localparam int LAT_MIN      = 3;
  localparam int LAT_MAX      = 15;
  localparam int ERR_HOLD_MAX = 3;

endpackage
`default_nettype wire

// File: rtl/job_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// job_responder : responder end of the req/ack job handshake with status pulses
// Rev 1.0
// ----------------------------------------------------------------------------
module job_responder
  import job_resp_pkg::*;
#(
  parameter int LATENCY  = 5,
  parameter int ERR_HOLD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic abort,
  input  logic fault,
  output logic ack,
  output logic rdy,
  output logic start,
  output logic endd,
  output logic stop,
  output logic er,
  output logic status_valid,
  output logic interrupt
);

  localparam int CW = $clog2(LATENCY);
  localparam logic [CW-1:0] c_lat_load = CW'(LATENCY - LAT_MIN);
  localparam logic [CW-1:0] c_err_load = CW'(ERR_HOLD - 1);
  localparam logic [CW-1:0] c_one      = CW'(1);

  generate
    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
      $error("job_responder: LATENCY must be within 3..15");
    end
    if (ERR_HOLD < 1 || ERR_HOLD > ERR_HOLD_MAX) begin : g_bad_err_hold
      $error("job_responder: ERR_HOLD must be within 1..3");
    end
  endgenerate

  job_state_e    r_state;
  logic [CW-1:0] r_cnt;   // RUN down-counter, reused as the ERR hold counter
  logic          r_flag;

  // Outputs are registered alongside the state, so each one reflects the state
  // it belongs to. rdy stays low until the first edge after reset release,
  // which is what keeps a req on that edge from being accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_flag       <= 1'b0;
      ack          <= 1'b0;
      rdy          <= 1'b0;
      start        <= 1'b0;
      endd         <= 1'b0;
      stop         <= 1'b0;
      er           <= 1'b0;
      status_valid <= 1'b0;
      interrupt    <= 1'b0;
    end else begin
      ack          <= 1'b0;
      rdy          <= 1'b0;
      start        <= 1'b0;
      endd         <= 1'b0;
      stop         <= 1'b0;
      er           <= 1'b0;
      status_valid <= 1'b0;
      interrupt    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rdy && req) begin
            r_state <= START;
            start   <= 1'b1;
          end else begin
            rdy <= 1'b1;
          end
        end
        START, RUN: begin
          if (fault) begin
            r_state   <= ERR;
            r_cnt     <= c_err_load;
            er        <= 1'b1;
            interrupt <= 1'b1;
          end else if (abort) begin
            r_state <= STOP;
            stop    <= 1'b1;
          end else if (r_state == START) begin
            r_state <= RUN;
            r_cnt   <= c_lat_load;
          end else if (r_cnt == '0) begin
            r_state   <= DONE;
            r_flag    <= 1'b1;
            ack       <= 1'b1;
            endd      <= 1'b1;
            interrupt <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end
        DONE, STOP: begin
          r_state      <= POST;
          status_valid <= r_flag;
        end
        ERR: begin
          if (r_cnt == '0) begin
            r_state      <= POST;
            status_valid <= r_flag;
          end else begin
            r_cnt <= r_cnt - c_one;
            er    <= 1'b1;
          end
        end
        POST: begin
          r_flag  <= 1'b0;
          r_state <= IDLE;
          rdy     <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_job_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_job_responder : cycle-trace scoreboard bench for job_responder
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_job_responder;

  localparam logic [7:0] M_ACK   = 8'h80;
  localparam logic [7:0] M_RDY   = 8'h40;
  localparam logic [7:0] M_START = 8'h20;
  localparam logic [7:0] M_ENDD  = 8'h10;
  localparam logic [7:0] M_STOP  = 8'h08;
  localparam logic [7:0] M_ER    = 8'h04;
  localparam logic [7:0] M_SV    = 8'h02;
  localparam logic [7:0] M_INT   = 8'h01;
  localparam logic [7:0] M_AEI   = M_ACK | M_ENDD | M_INT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic abort = 1'b0;
  logic fault = 1'b0;
  logic ack, rdy, start, endd, stop, er, status_valid, interrupt;
  logic [7:0] obs;

  int compared = 0;
  int mismatched = 0;
  logic [7:0] exp_q[$];

  assign obs = {ack, rdy, start, endd, stop, er, status_valid, interrupt};

  job_responder #(.LATENCY(5), .ERR_HOLD(2)) dut (
    .clk(clk), .rst(rst), .req(req), .abort(abort), .fault(fault),
    .ack(ack), .rdy(rdy), .start(start), .endd(endd), .stop(stop),
    .er(er), .status_valid(status_valid), .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  // Output bit order in every trace: ack rdy start endd stop er status_valid interrupt
  task automatic test_reset();
    logic [31:0] rs, rq;
    logic [7:0] e[32];
    logic [7:0] want;
    rs = '1; rq = '0;
    for (int k = 0; k < 32; k++) e[k] = 8'h00;
    rs[0] = 1'b0; rs[1] = 1'b0;
    for (int k = 0; k < 10; k++) rq[k] = 1'b1;
    e[3] = M_RDY; e[4] = M_START; e[8] = M_AEI; e[9] = M_SV; e[10] = M_RDY; e[11] = M_RDY;
    for (int k = 0; k < 12; k++) exp_q.push_back(e[k]);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rst = rs[k]; req = rq[k]; abort = 1'b0; fault = 1'b0;
      #1;
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL reset_release cycle %0d: got %b want %b", k, obs, want);
      end
    end
  endtask

  task automatic test_fault();
    logic [31:0] rq, ft;
    logic [7:0] e[32];
    logic [7:0] want;
    rq = '0; ft = '0;
    for (int k = 0; k < 32; k++) e[k] = 8'h00;
    rq[0] = 1'b1; ft[3] = 1'b1;
    e[0] = M_RDY; e[1] = M_START; e[4] = M_ER | M_INT; e[5] = M_ER; e[7] = M_RDY; e[8] = M_RDY;
    for (int k = 0; k < 9; k++) exp_q.push_back(e[k]);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      req = rq[k]; abort = 1'b0; fault = ft[k];
      #1;
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL fault cycle %0d: got %b want %b", k, obs, want);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rq, ab;
    logic [7:0] e[32];
    logic [7:0] want;
    rq = '0; ab = '0;
    for (int k = 0; k < 32; k++) e[k] = 8'h00;
    rq[0] = 1'b1; ab[2] = 1'b1;   // abort during RUN
    rq[5] = 1'b1; ab[6] = 1'b1;   // abort during START
    e[0] = M_RDY; e[1] = M_START; e[3] = M_STOP; e[5] = M_RDY;
    e[6] = M_START; e[7] = M_STOP; e[9] = M_RDY;
    for (int k = 0; k < 10; k++) exp_q.push_back(e[k]);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      req = rq[k]; abort = ab[k]; fault = 1'b0;
      #1;
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL abort cycle %0d: got %b want %b", k, obs, want);
      end
    end
  endtask

  task automatic test_fault_abort();
    logic [31:0] rq, ab, ft;
    logic [7:0] e[32];
    logic [7:0] want;
    rq = '0; ab = '0; ft = '0;
    for (int k = 0; k < 32; k++) e[k] = 8'h00;
    rq[0] = 1'b1; ab[2] = 1'b1; ft[2] = 1'b1;
    e[0] = M_RDY; e[1] = M_START; e[3] = M_ER | M_INT; e[4] = M_ER; e[6] = M_RDY;
    for (int k = 0; k < 7; k++) exp_q.push_back(e[k]);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      req = rq[k]; abort = ab[k]; fault = ft[k];
      #1;
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL fault_abort cycle %0d: got %b want %b", k, obs, want);
      end
    end
  endtask

  task automatic test_ignored();
    logic [31:0] rq, ab, ft;
    logic [7:0] e[32];
    logic [7:0] want;
    rq = '0; ab = '0; ft = '0;
    for (int k = 0; k < 32; k++) e[k] = 8'h00;
    rq[0] = 1'b1; rq[2] = 1'b1; rq[3] = 1'b1; rq[6] = 1'b1;
    ab[0] = 1'b1; ab[5] = 1'b1; ft[6] = 1'b1; ft[7] = 1'b1;
    e[0] = M_RDY; e[1] = M_START; e[5] = M_AEI; e[6] = M_SV; e[7] = M_RDY; e[8] = M_RDY;
    for (int k = 0; k < 9; k++) exp_q.push_back(e[k]);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      req = rq[k]; abort = ab[k]; fault = ft[k];
      #1;
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL ignored_inputs cycle %0d: got %b want %b", k, obs, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rq;
    logic [7:0] e[32];
    logic [7:0] want;
    rq = '0;
    for (int k = 0; k < 32; k++) e[k] = 8'h00;
    for (int k = 0; k < 14; k++) rq[k] = 1'b1;
    e[0] = M_RDY; e[1] = M_START; e[5] = M_AEI; e[6] = M_SV;
    e[7] = M_RDY; e[8] = M_START; e[12] = M_AEI; e[13] = M_SV;
    e[14] = M_RDY; e[15] = M_RDY;
    for (int k = 0; k < 16; k++) exp_q.push_back(e[k]);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      req = rq[k]; abort = 1'b0; fault = 1'b0;
      #1;
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", k, obs, want);
      end
    end
  endtask

  task automatic test_reset_mid_job();
    logic [31:0] rs, rq;
    logic [7:0] e[32];
    logic [7:0] want;
    rs = '1; rq = '0;
    for (int k = 0; k < 32; k++) e[k] = 8'h00;
    rs[3] = 1'b0; rs[4] = 1'b0;     // reset during RUN
    rs[15] = 1'b0; rs[16] = 1'b0;   // reset during START, must clear start at once
    rq[0] = 1'b1; rq[5] = 1'b1; rq[7] = 1'b1; rq[14] = 1'b1;
    e[0] = M_RDY; e[1] = M_START; e[6] = M_RDY; e[7] = M_RDY; e[8] = M_START;
    e[12] = M_AEI; e[13] = M_SV; e[14] = M_RDY; e[18] = M_RDY; e[19] = M_RDY;
    for (int k = 0; k < 20; k++) exp_q.push_back(e[k]);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      rst = rs[k]; req = rq[k]; abort = 1'b0; fault = 1'b0;
      #1;
      want = exp_q.pop_front();
      compared++;
      if (obs !== want) begin
        mismatched++;
        $display("FAIL reset_mid_job cycle %0d: got %b want %b", k, obs, want);
      end
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    test_reset();
    test_fault();
    test_abort();
    test_fault_abort();
    test_ignored();
    test_back_to_back();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
